// File: rtl/sort_compare_sequencer_pkg.sv
// Shared types and ALU opcodes for the bubble-sort offload sequencer.
package sort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        CMP,
        WR0,
        WR1,
        DONE
    } sort_state_t;

    localparam logic [3:0] ALUOP_AND  = 4'b0000;
    localparam logic [3:0] ALUOP_OR   = 4'b0001;
    localparam logic [3:0] ALUOP_ADD  = 4'b0010;
    localparam logic [3:0] ALUOP_SUB  = 4'b0110;
    localparam logic [3:0] ALUOP_NOR  = 4'b1100;
    localparam logic [3:0] ALUOP_SLLI = 4'b1000;

endpackage

// File: rtl/sort_compare_sequencer_index_counter.sv
// Pass / inner-index bookkeeping for the bubble sort, with end-of-pass decode.
module sort_index_counter #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] j,
    output logic [AW-1:0] j_next,
    output logic          last_compare,
    output logic          last_pass
);

    localparam logic [AW-1:0] LAST_J = AW'(N - 2);

    logic [AW-1:0] pass;

    // Each pass bubbles one more maximum into place, so the inner range shrinks.
    assign last_compare = (j == LAST_J - pass);
    assign last_pass    = (pass == LAST_J);
    assign j_next       = j + AW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            j    <= '0;
            pass <= '0;
        end else if (clear) begin
            j    <= '0;
            pass <= '0;
        end else if (advance) begin
            if (!last_compare) begin
                j <= j_next;
            end else if (!last_pass) begin
                pass <= pass + AW'(1);
                j    <= '0;
            end
        end
    end

endmodule

// File: rtl/sort_compare_sequencer.sv
// Bubble-sort controller driving the EX-stage ALU and a synchronous scratch RAM.
// Optional early exit on a swap-free pass: define SORT_EARLY_EXIT_EN.
module sort_compare_sequencer
    import sort_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 64,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [W-1:0]  mem_wdata,
    input  logic [W-1:0]  mem_rdata,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_op,
    input  logic          alu_zero,
    input  logic          alu_is_greater,
    output logic [15:0]   swap_count
);

    sort_state_t   state;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [AW-1:0] j;
    logic [AW-1:0] j_next;
    logic          last_compare;
    logic          last_pass;
    logic          swap;
    logic          advance;
    logic          finish;

    // The ALU flags a<b on Is_Greater, so x>y is "neither equal nor less".
    assign swap    = !alu_zero && !alu_is_greater;
    assign advance = ((state == CMP) && !swap) || (state == WR1);
    assign alu_a   = x;
    assign alu_b   = y;

    sort_index_counter #(.N(N), .AW(AW)) u_index (
        .clk          (clk),
        .reset        (reset),
        .clear        ((state == IDLE) && start),
        .advance      (advance),
        .j            (j),
        .j_next       (j_next),
        .last_compare (last_compare),
        .last_pass    (last_pass)
    );

`ifdef SORT_EARLY_EXIT_EN
    logic pass_swapped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_swapped <= 1'b0;
        end else if ((state == IDLE) && start) begin
            pass_swapped <= 1'b0;
        end else if (advance && last_compare) begin
            pass_swapped <= 1'b0;
        end else if (state == WR1) begin
            pass_swapped <= 1'b1;
        end
    end

    // A swap landing in this very cycle still counts for the current pass.
    assign finish = last_compare && (last_pass || !(pass_swapped || (state == WR1)));
`else
    assign finish = last_compare && last_pass;
`endif

    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        alu_op   = ALUOP_AND;
        case (state)
            RD0: mem_addr = j;
            RD1: mem_addr = j_next;
            CMP: alu_op   = ALUOP_SUB;
            WR0: begin
                mem_we   = 1'b1;
                mem_addr = j;
            end
            WR1: begin
                mem_we   = 1'b1;
                mem_addr = j_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_wdata  <= '0;
            x          <= '0;
            y          <= '0;
            swap_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RD0;
                        busy       <= 1'b1;
                        swap_count <= '0;
                    end
                end
                RD0: state <= RD1;
                RD1: begin
                    x     <= mem_rdata;
                    state <= RD2;
                end
                RD2: begin
                    y     <= mem_rdata;
                    state <= CMP;
                end
                CMP: begin
                    if (swap) begin
                        mem_wdata <= y;
                        state     <= WR0;
                    end else if (finish) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RD0;
                    end
                end
                WR0: begin
                    mem_wdata <= x;
                    state     <= WR1;
                end
                WR1: begin
                    if (swap_count != 16'hFFFF) begin
                        swap_count <= swap_count + 16'd1;
                    end
                    if (finish) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RD0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_compare_sequencer.sv
// Self-checking bench for sort_compare_sequencer at N=4 with a behavioural RAM and ALU.
module tb_sort_compare_sequencer;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata = '0;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_op;
    logic          alu_zero;
    logic          alu_is_greater;
    logic [15:0]   swap_count;

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic [W-1:0]  ram [N];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0][63:0] init;
        logic [3:0][63:0] sorted;
        int               swaps;
        int               cmps_off;
        int               cmps_on;
        int               cyc_off;
        int               cyc_on;
    } vec_t;

    vec_t table_v [5];
    vec_t exp_q [$];

    always #5 clk = ~clk;

    sort_compare_sequencer #(.N(N), .W(W), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .alu_zero       (alu_zero),
        .alu_is_greater (alu_is_greater),
        .swap_count     (swap_count)
    );

    assign alu_zero       = (alu_a == alu_b);
    assign alu_is_greater = (alu_a < alu_b);

    // Synchronous-read scratch RAM, with a side port for preloading.
    always @(posedge clk) begin
        if (load_en) begin
            ram[load_addr] <= load_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    function automatic vec_t mk(input logic [63:0] a0, a1, a2, a3,
                                input logic [63:0] e0, e1, e2, e3,
                                input int sw, co, cn, yo, yn);
        vec_t v;
        v.init[0] = a0; v.init[1] = a1; v.init[2] = a2; v.init[3] = a3;
        v.sorted[0] = e0; v.sorted[1] = e1; v.sorted[2] = e2; v.sorted[3] = e3;
        v.swaps = sw; v.cmps_off = co; v.cmps_on = cn; v.cyc_off = yo; v.cyc_on = yn;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        for (int i = 0; i < N; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = v.init[i];
            @(negedge clk);
        end
        load_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_we"},    64'(mem_we), 64'd0);
        check({tag, "_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_wdata"}, mem_wdata, 64'd0);
        check({tag, "_alu_a"}, alu_a, 64'd0);
        check({tag, "_alu_b"}, alu_b, 64'd0);
        check({tag, "_aluop"}, 64'(alu_op), 64'd0);
        check({tag, "_swaps"}, 64'(swap_count), 64'd0);
    endtask

    // Pulses start, then watches every cycle until done (bounded).
    task automatic run_sort(input int mid_start, input bit start_in_done,
                            output int cyc, output int cmps, output int wes);
        logic [AW-1:0] h1, h2, h3;
        bit            got_done;
        int            idx;
        h1 = '0; h2 = '0; h3 = '0;
        cyc = 0; cmps = 0; wes = 0; got_done = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            start = (t == mid_start);
            if (done) begin
                check("busy_in_done", 64'(busy), 64'd1);
                got_done = 1;
                start = start_in_done;
                @(negedge clk);
                start = 1'b0;
                break;
            end
            if (!busy) check("busy_held", 64'(busy), 64'd1);
            cyc++;
            if (mem_we) wes++;
            if (alu_op == 4'b0110) begin
                cmps++;
                idx = int'(h3);
                if (idx < N - 1) begin
                    check("cmp_alu_a", alu_a, ram[idx]);
                    check("cmp_alu_b", alu_b, ram[idx+1]);
                end else begin
                    check("cmp_index", 64'(idx), 64'(N - 2));
                end
                check("cmp_we", 64'(mem_we), 64'd0);
            end else if (alu_op != 4'b0000) begin
                check("alu_op_idle", 64'(alu_op), 64'd0);
            end
            h3 = h2; h2 = h1; h1 = mem_addr;
            @(negedge clk);
        end
        check("done_seen", 64'(got_done), 64'd1);
        check("done_pulse", 64'(done), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic check_output(input int cyc, input int cmps, input int wes);
        vec_t v;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        v = exp_q.pop_front();
        check("swap_count", 64'(swap_count), 64'(v.swaps));
        check("we_cycles", 64'(wes), 64'(2 * v.swaps));
`ifdef SORT_EARLY_EXIT_EN
        check("compares", 64'(cmps), 64'(v.cmps_on));
        check("cycles", 64'(cyc), 64'(v.cyc_on));
`else
        check("compares", 64'(cmps), 64'(v.cmps_off));
        check("cycles", 64'(cyc), 64'(v.cyc_off));
`endif
        for (int i = 0; i < N; i++) begin
            check($sformatf("ram%0d", i), ram[i], v.sorted[i]);
        end
    endtask

    initial begin
        int   cyc, cmps, wes;
        bit   found;
        vec_t v;
        reset = 1'b0; start = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        table_v[0] = mk(4, 3, 2, 1, 1, 2, 3, 4, 6, 6, 6, 36, 36);
        table_v[1] = mk(1, 2, 3, 4, 1, 2, 3, 4, 0, 6, 3, 24, 12);
        table_v[2] = mk(5, 5, 64'hFFFF_FFFF_FFFF_FFFF, 0,
                        0, 5, 5, 64'hFFFF_FFFF_FFFF_FFFF, 3, 6, 6, 30, 30);
        table_v[3] = mk(2, 1, 3, 4, 1, 2, 3, 4, 1, 6, 5, 26, 22);
        table_v[4] = mk(3, 1, 4, 2, 1, 2, 3, 4, 3, 6, 6, 30, 30);

        for (int k = 0; k < 5; k++) begin
            apply_stimulus(table_v[k]);
            exp_q.push_back(table_v[k]);
            run_sort(-1, 1'b0, cyc, cmps, wes);
            check_output(cyc, cmps, wes);
        end

        // Start pulses while busy and during done must not disturb the sort.
        apply_stimulus(table_v[0]);
        exp_q.push_back(table_v[0]);
        run_sort(10, 1'b1, cyc, cmps, wes);
        check_output(cyc, cmps, wes);
        // A start in the very next IDLE cycle is accepted (RAM already sorted).
        exp_q.push_back(table_v[1]);
        run_sort(-1, 1'b0, cyc, cmps, wes);
        check_output(cyc, cmps, wes);

        // Reset during WR1 of the second compare: only WR0's write has landed.
        apply_stimulus(table_v[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int t = 0; t < 200; t++) begin
            if (mem_we && mem_addr == 2'd2) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("wr1_found", 64'(found), 64'd1);
        #1 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_ram0", ram[0], 64'd3);
        check("post_reset_ram1", ram[1], 64'd2);
        check("post_reset_ram2", ram[2], 64'd2);
        check("post_reset_ram3", ram[3], 64'd1);
        v = mk(3, 2, 2, 1, 1, 2, 2, 3, 5, 6, 6, 34, 34);
        exp_q.push_back(v);
        run_sort(-1, 1'b0, cyc, cmps, wes);
        check_output(cyc, cmps, wes);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sort_compare_sequencer.md
Name: sort_compare_sequencer

Overview:
- Multi-cycle bubble-sort controller that drives the 64-bit ALU.
  - Drives: operands and ALUOp.
  - Consumes: the zero and Is_Greater flags.
- Sorts N unsigned 64-bit words in place in a data scratch RAM, ascending order.
- Sits beside the EX stage as a hardware sort offload.
- Software pulses start, then waits for done.

Parameters:
- N, 8: element count; must be ≥2.
- W, 64: data width; matches ALU width.
- AW, 3: RAM address width; equals clog2(N).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a sort; ignored while busy.
- busy  out  1  high from the cycle after start through the DONE state.
- done  out  1  one-cycle pulse when the sort is complete.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  W  RAM write data.
- mem_rdata  in  W  RAM read data; valid one cycle after mem_addr (synchronous read).
- alu_a  out  W  ALU operand a; always the held element x.
- alu_b  out  W  ALU operand b; always the held element y.
- alu_op  out  4  4'b0110 (subtract) in CMP, 4'b0000 otherwise.
- alu_zero  in  1  ALU zero flag (a==b).
- alu_is_greater  in  1  ALU Is_Greater flag; asserted when a<b, unsigned.
- swap_count  out  16  swaps performed in the current/last sort; saturates at 16'hFFFF.

Behaviour:
- Reset values (reset low): state=IDLE; busy=0; done=0; mem_we=0; mem_addr=0; mem_wdata=0; x=y=0; alu_op=0; pass=0; j=0; swap_count=0.
- FSM states: IDLE, RD0, RD1, RD2, CMP, WR0, WR1, DONE.
- IDLE: on start → RD0; clear pass, j, swap_count and the pass-swap flag.
- RD0: mem_addr=j.
- RD1: mem_addr=j+1; x<=mem_rdata.
- RD2: y<=mem_rdata.
- CMP: alu_op=0110.
  - swap = !alu_zero && !alu_is_greater (x>y, unsigned).
  - Equal elements are never swapped, so the sort is stable.
  - swap → WR0.
  - No swap → advance (see below).
- WR0: mem_we=1, mem_addr=j, mem_wdata=y.
- WR1: mem_we=1, mem_addr=j+1, mem_wdata=x; swap_count++ (saturating); set pass-swap flag; then advance.
- Advance:
  - If j < N-2-pass: j++ → RD0.
  - Else, if pass < N-2: pass++, j=0, clear pass-swap flag → RD0.
  - Else → DONE.
- DONE: done=1 for exactly one cycle, busy=1 → IDLE.
- busy=0 in IDLE only.
- Cycle cost: 4 cycles per compare without swap, 6 with swap. Total compares = N(N-1)/2 unless early exit (see Optional Feature).
- mem_we is high only in WR0 and WR1.
- Outputs are registered except alu_op, mem_addr and mem_we, which are decoded from the state register.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as done: ignored; a new start is accepted in the following IDLE cycle.
  - Reset mid-sort: immediate return to IDLE; RAM is left partially sorted but never holds a half-written pair beyond the single write in flight.
  - Arithmetic: j+1 never exceeds N-1; indexes do not wrap.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined: at each pass end, if the pass-swap flag is 0, go to DONE instead of starting the next pass. An already-sorted array finishes after N-1 compares.
- Undefined: all N-1 passes always run.

Decomposition:
- Shared package sort_pkg holds:
  - state enum sort_state_t.
  - ALUOP_AND=4'b0000, ALUOP_OR=4'b0001, ALUOP_ADD=4'b0010, ALUOP_SUB=4'b0110, ALUOP_NOR=4'b1100, ALUOP_SLLI=4'b1000.
- One natural sub-module: sort_index_counter, which holds pass/j and produces the advance/last-compare/last-pass decode.

Test Plan:
- N=4, RAM {4,3,2,1}, start → done after 6 compares (6 swaps, 36 cycles + DONE); RAM {1,2,3,4}; swap_count=6.
- N=4, RAM {1,2,3,4}, macro off → 6 compares, 24 cycles + DONE, swap_count=0, mem_we never high. Macro on → done after 12 cycles + DONE.
- RAM {5,5,0xFFFF_FFFF_FFFF_FFFF,0} → {0,5,5,0xFFFF_FFFF_FFFF_FFFF}; unsigned ordering; no swap on the equal pair.
- Assert reset low during WR1 of the second compare → outputs immediately take reset values; a restart then sorts correctly.
- Pulse start while busy and in the done cycle → no restart; busy/done timing unchanged.
- Check alu_op=0110 only in CMP, with alu_a/alu_b equal to RAM[j]/RAM[j+1] at that cycle.
